// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants, state encoding and width helper for the seven-segment scan driver
// Contents:
//   SEG_0..SEG_F, SEG_OFF : a..g patterns, active-low, bit 6 = a, bit 0 = g
//   ST_IDLE/GUARD/DRIVE   : scan state encoding
//   clog2                 : counter width helper, never returns less than 1
package sseg_pkg;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GUARD = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    // Width needed to hold 0..value-1; a one-bit minimum keeps single-value counters legal.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// rtl/sseg_decode.sv - 4-bit code to active-low a..g segment decoder
// Ports:
//   code : 4-bit digit code
//   seg  : a..g, active-low, bit 6 = a
// Build option SSEG_HEX_EN: defined, codes 10..15 show A b C d E F; undefined, they stay dark.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
`ifdef SSEG_HEX_EN
            4'd10:   seg = SEG_A;
            4'd11:   seg = SEG_B;
            4'd12:   seg = SEG_C;
            4'd13:   seg = SEG_D;
            4'd14:   seg = SEG_E;
            4'd15:   seg = SEG_F;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: seg = SEG_OFF;
`endif
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - time-multiplexed common-anode seven-segment scan driver
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   enable       : scan enable; low parks the driver dark in IDLE
//   digits_in    : packed codes, digit i at [4i+3:4i], digit 0 least significant
//   dp_in        : decimal point per digit, 1 = lit
//   blank_in     : 1 = digit dark for its whole slot
//   an_n         : anode select, active-low, one-hot-low while driving
//   sseg_n       : {dp, a..g}, active-low
//   frame_start  : one-cycle pulse on the first cycle of slot 0
// Build option SSEG_HEX_EN selects hex glyphs for codes 10..15 (see sseg_decode).
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_SUPPRESS  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [7:0]              sseg_n,
    output logic                    frame_start
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int PRE_W = clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W:0]   GUARD_END = (PRE_W + 1)'(BLANK_CYCLES);

    logic [1:0]              state, nxt_state;
    logic [PRE_W-1:0]        pre, nxt_pre;
    logic [IDX_W-1:0]        idx, nxt_idx;
    logic [4*NUM_DIGITS-1:0] shd_digits, nxt_digits;
    logic [NUM_DIGITS-1:0]   shd_dp, nxt_dp;
    logic [NUM_DIGITS-1:0]   shd_blank, nxt_blank;
    logic                    load;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    upper_zero;
    logic [3:0]              cur_code;
    logic [6:0]              cur_seg;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   an_nxt;

    // Everything is resolved for the cycle being entered, so the registered
    // outputs match the state/idx/shadow they are registered alongside.
    always_comb begin
        nxt_state = state;
        nxt_pre   = pre;
        nxt_idx   = idx;
        load      = 1'b0;
        if (!enable) begin
            nxt_state = ST_IDLE;
            nxt_pre   = '0;
            nxt_idx   = '0;
        end else begin
            if (state == ST_IDLE) begin
                nxt_pre = '0;
                nxt_idx = '0;
                load    = 1'b1;
            end else if (pre == PRE_LAST) begin
                nxt_pre = '0;
                if (idx == IDX_LAST) begin
                    nxt_idx = '0;
                    load    = 1'b1;
                end else begin
                    nxt_idx = idx + 1'b1;
                end
            end else begin
                nxt_pre = pre + 1'b1;
            end
            nxt_state = ({1'b0, nxt_pre} < GUARD_END) ? ST_GUARD : ST_DRIVE;
        end
        nxt_digits = load ? digits_in : shd_digits;
        nxt_dp     = load ? dp_in     : shd_dp;
        nxt_blank  = load ? blank_in  : shd_blank;
    end

    // Digit i is a leading zero when it and every more-significant digit are 0.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        if (LZ_SUPPRESS != 0) begin
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                upper_zero = upper_zero & (nxt_digits[4*i +: 4] == 4'd0);
                lz_mask[i] = upper_zero;
            end
        end
    end

    assign cur_code = nxt_digits[{nxt_idx, 2'b00} +: 4];

    sseg_decode u_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

    always_comb begin
        dark           = (nxt_state != ST_DRIVE) | nxt_blank[nxt_idx] | lz_mask[nxt_idx];
        an_nxt         = '1;
        an_nxt[nxt_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pre         <= '0;
            idx         <= '0;
            shd_digits  <= '0;
            shd_dp      <= '0;
            shd_blank   <= '1;
            an_n        <= '1;
            sseg_n      <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            state       <= nxt_state;
            pre         <= nxt_pre;
            idx         <= nxt_idx;
            shd_digits  <= nxt_digits;
            shd_dp      <= nxt_dp;
            shd_blank   <= nxt_blank;
            frame_start <= load;
            if (dark) begin
                an_n   <= '1;
                sseg_n <= 8'hFF;
            end else begin
                an_n   <= an_nxt;
                sseg_n <= {~nxt_dp[nxt_idx], cur_seg};
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - self-checking bench for sseg_scan_driver
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  an0, an1;
    logic [7:0]  sg0, sg1;
    logic        fs0, fs1;

    int tests = 0;
    int fails = 0;

`ifdef SSEG_HEX_EN
    localparam logic [7:0] HA = 8'h88, HC = 8'hB1, HD = 8'hC2, HE = 8'hB0, HF = 8'hB8;
`else
    localparam logic [7:0] HA = 8'hFF, HC = 8'hFF, HD = 8'hFF, HE = 8'hFF, HF = 8'hFF;
`endif

    sseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .an_n(an0), .sseg_n(sg0), .frame_start(fs0)
    );

    sseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(1)) dut_lz (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .an_n(an1), .sseg_n(sg1), .frame_start(fs1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lz;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  dark;
        logic [31:0] seg;
    } vec_t;

    vec_t vecs[9];

    localparam logic [31:0] SEG_1234 = {8'hCF, 8'h92, 8'h86, 8'hCC};
    localparam logic [31:0] SEG_5678 = {8'hA4, 8'hA0, 8'h8F, 8'h80};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] obs(input logic lz);
        return lz ? {fs1, an1, sg1} : {fs0, an0, sg0};
    endfunction

    // Expected {frame_start, an_n, sseg_n} at slot s, slot cycle c.
    function automatic logic [12:0] expv(input int s, input int c, input logic [3:0] dark,
                                         input logic [31:0] seg);
        logic       fs;
        logic [3:0] an;
        fs = (s == 0) && (c == 0);
        if (c < 2 || dark[s]) return {fs, 4'hF, 8'hFF};
        an    = 4'hF;
        an[s] = 1'b0;
        return {fs, an, seg[8*s +: 8]};
    endfunction

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got fs/an/sseg=%b/%b/%h, expected %b/%b/%h",
                     name, act[12], act[11:8], act[7:0], exp[12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic run_vec(input int i);
        enable = 1'b0;
        step();
        digits_in = vecs[i].digits;
        dp_in     = vecs[i].dp;
        blank_in  = vecs[i].blank;
        enable    = 1'b1;
        step();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("vec%0d s%0d c%0d", i, s, c), obs(vecs[i].lz),
                    expv(s, c, vecs[i].dark, vecs[i].seg));
                step();
            end
        end
        chk($sformatf("vec%0d wrap", i), obs(vecs[i].lz), expv(0, 0, vecs[i].dark, vecs[i].seg));
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h1234, 4'b0000, 4'b0000, 4'b0000, SEG_1234};
        vecs[1] = '{1'b0, 16'h5678, 4'b0000, 4'b0000, 4'b0000, SEG_5678};
        vecs[2] = '{1'b1, 16'h0007, 4'b0100, 4'b0000, 4'b1110, {8'hFF, 8'hFF, 8'hFF, 8'h8F}};
        vecs[3] = '{1'b1, 16'h0000, 4'b0000, 4'b0000, 4'b1110, {8'hFF, 8'hFF, 8'hFF, 8'h81}};
        vecs[4] = '{1'b0, 16'h000A, 4'b0000, 4'b0010, 4'b0010, {8'h81, 8'h81, 8'hFF, HA}};
        vecs[5] = '{1'b0, 16'h9080, 4'b1010, 4'b0000, 4'b0000, {8'h04, 8'h81, 8'h00, 8'h81}};
        vecs[6] = '{1'b1, 16'h0900, 4'b0001, 4'b0000, 4'b1000, {8'hFF, 8'h84, 8'h81, 8'h01}};
        vecs[7] = '{1'b0, 16'hFEDC, 4'b0000, 4'b0000, 4'b0000, {HF, HE, HD, HC}};
        vecs[8] = '{1'b0, 16'h1234, 4'b0000, 4'b1111, 4'b1111, SEG_1234};

        rst_n = 1'b0; enable = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
        step();
        step();
        chk("reset dut", obs(1'b0), {1'b0, 4'hF, 8'hFF});
        chk("reset dut_lz", obs(1'b1), {1'b0, 4'hF, 8'hFF});
        rst_n = 1'b1;
        step();
        chk("idle", obs(1'b0), {1'b0, 4'hF, 8'hFF});

        for (int i = 0; i < 9; i++) run_vec(i);

        // Asynchronous reset in the middle of a DRIVE slot.
        enable = 1'b0;
        step();
        digits_in = 16'h1234; dp_in = '0; blank_in = '0; enable = 1'b1;
        step();
        step(); step(); step();
        chk("pre-reset drive", obs(1'b0), expv(0, 3, 4'b0, SEG_1234));
        #2 rst_n = 1'b0;
        #1 chk("async reset", obs(1'b0), {1'b0, 4'hF, 8'hFF});
        step();
        rst_n = 1'b1;
        step();
        chk("post-reset frame", obs(1'b0), expv(0, 0, 4'b0, SEG_1234));

        // Mid-frame input change must not tear the current frame.
        for (int c = 0; c < 8; c++) step();
        digits_in = 16'h5678;
        for (int s = 1; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("notear s%0d c%0d", s, c), obs(1'b0), expv(s, c, 4'b0, SEG_1234));
                step();
            end
        end
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("newframe s0 c%0d", c), obs(1'b0), expv(0, c, 4'b0, SEG_5678));
            step();
        end

        // Enable dropped at slot 2 cycle 5, then reasserted.
        for (int c = 0; c < 13; c++) step();
        chk("s2c5 before drop", obs(1'b0), expv(2, 5, 4'b0, SEG_5678));
        enable = 1'b0;
        step();
        chk("drop idle 1", obs(1'b0), {1'b0, 4'hF, 8'hFF});
        step();
        chk("drop idle 2", obs(1'b0), {1'b0, 4'hF, 8'hFF});
        enable = 1'b1;
        step();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("restart s0 c%0d", c), obs(1'b0), expv(0, c, 4'b0, SEG_5678));
            step();
        end
        chk("restart s1 c0", obs(1'b0), expv(1, 0, 4'b0, SEG_5678));
        step(); step();
        chk("restart s1 c2", obs(1'b0), expv(1, 2, 4'b0, SEG_5678));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
